// File: rtl/aes_pkg.sv
// Shared types for the AES batch loader and its lane banks.
// Optional build macro: AES_LOADER_FLUSH_EN (partial-batch flush).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef struct packed {
    aes_block_t plain;
    aes_block_t key;
  } aes_lane_pair_t;

  function automatic int lane_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_batch_bank.sv
// One N-lane bank of {plain, key} pairs with per-lane write enable.
// AES_LOADER_FLUSH_EN adds a lane mask that zeroes unwritten lanes.
module aes_batch_bank
  import aes_pkg::*;
#(
  parameter int N  = 10,
  parameter int LW = lane_w(N)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_we,
  input  logic [LW-1:0]            i_lane,
  input  logic [AES_BLOCK_W-1:0]   i_plain,
  input  logic [AES_BLOCK_W-1:0]   i_key,
`ifdef AES_LOADER_FLUSH_EN
  input  logic                     i_mask_we,
  input  logic [N-1:0]             i_mask,
  output logic [N-1:0]             o_mask,
`endif
  output logic [AES_BLOCK_W*N-1:0] o_plain,
  output logic [AES_BLOCK_W*N-1:0] o_key
);

  aes_lane_pair_t r_lane [N];
  logic [N-1:0]   w_keep;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N; j++) r_lane[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (i_we && i_lane == LW'(j)) begin
          r_lane[j].plain <= i_plain;
          r_lane[j].key   <= i_key;
        end
      end
    end
  end

`ifdef AES_LOADER_FLUSH_EN
  logic [N-1:0] r_mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_mask <= '0;
    else if (i_mask_we) r_mask <= i_mask;
  end

  assign o_mask = r_mask;
  assign w_keep = r_mask;
`else
  assign w_keep = '1;
`endif

  // Stale lanes from an earlier batch must not leak into a flushed one
  always_comb begin
    o_plain = '0;
    o_key   = '0;
    for (int j = 0; j < N; j++) begin
      if (w_keep[j]) begin
        o_plain[j*AES_BLOCK_W +: AES_BLOCK_W] = r_lane[j].plain;
        o_key[j*AES_BLOCK_W +: AES_BLOCK_W]   = r_lane[j].key;
      end
    end
  end

endmodule

// File: rtl/aes_batch_loader.sv
// Ping-pong batch packer feeding the N-lane AES core.
// Optional build macro: AES_LOADER_FLUSH_EN (flush input, lane_mask output).
module aes_batch_loader
  import aes_pkg::*;
#(
  parameter int N     = 10,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AES_BLOCK_W-1:0]   in_plain_text,
  input  logic [AES_BLOCK_W-1:0]   in_cipher_key,
  output logic                     start,
  output logic [AES_BLOCK_W*N-1:0] plain_text,
  output logic [AES_BLOCK_W*N-1:0] cipher_key,
  input  logic                     done,
  output logic [CNT_W-1:0]         batches_issued,
  output logic                     done_err
`ifdef AES_LOADER_FLUSH_EN
  ,
  input  logic                     flush,
  output logic [N-1:0]             lane_mask
`endif
);

  localparam int LW = lane_w(N);
  localparam logic [LW-1:0] LAST = LW'(N-1);

  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LW-1:0]    r_wr_lane;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done_err;

  logic       w_acc;
  logic       w_last;
  logic       w_seal;
  logic       w_retire;
  logic [1:0] w_we;
  logic [1:0] w_set;
  logic [1:0] w_clr;

  logic [AES_BLOCK_W*N-1:0] w_pt  [2];
  logic [AES_BLOCK_W*N-1:0] w_key [2];

  assign in_ready = !r_full[r_wr_bank];
  assign start    = r_full[r_rd_bank];
  assign w_acc    = in_valid && in_ready;
  assign w_last   = w_acc && (r_wr_lane == LAST);
  assign w_retire = done && start;

`ifdef AES_LOADER_FLUSH_EN
  logic [LW:0]  w_fill;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_bmask [2];

  // A beat arriving with flush counts as written before sealing
  assign w_fill = {1'b0, r_wr_lane} + (LW+1)'(w_acc);
  assign w_seal = w_last || (flush && w_fill != '0);

  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = ((LW+1)'(j) < w_fill);
    end
  end

  assign lane_mask = r_rd_bank ? w_bmask[1] : w_bmask[0];
`else
  assign w_seal = w_last;
`endif

  assign w_we  = {w_acc && r_wr_bank, w_acc && !r_wr_bank};
  assign w_set = {w_seal && r_wr_bank, w_seal && !r_wr_bank};
  assign w_clr = {w_retire && r_rd_bank, w_retire && !r_rd_bank};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_lane  <= '0;
      r_cnt      <= '0;
      r_done_err <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      if (w_seal) begin
        r_wr_bank <= !r_wr_bank;
        r_wr_lane <= '0;
      end else if (w_acc) begin
        r_wr_lane <= r_wr_lane + LW'(1);
      end
      if (w_retire) begin
        r_rd_bank <= !r_rd_bank;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (done && !start) r_done_err <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    aes_batch_bank #(
      .N  (N),
      .LW (LW)
    ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .i_we      (w_we[b]),
      .i_lane    (r_wr_lane),
      .i_plain   (in_plain_text),
      .i_key     (in_cipher_key),
`ifdef AES_LOADER_FLUSH_EN
      .i_mask_we (w_set[b]),
      .i_mask    (w_mask),
      .o_mask    (w_bmask[b]),
`endif
      .o_plain   (w_pt[b]),
      .o_key     (w_key[b])
    );
  end

  assign plain_text     = r_rd_bank ? w_pt[1]  : w_pt[0];
  assign cipher_key     = r_rd_bank ? w_key[1] : w_key[0];
  assign batches_issued = r_cnt;
  assign done_err       = r_done_err;

endmodule
